tff_counter_scheduler: RTL and testbench
========================================

// Module: tff_counter_scheduler
// PURPOSE
//  Time-shares one CW-bit synchronous up counter (T flip-flop style) among NREQ requesters.
//  Each requester asks for an interval of len+1 clock cycles.
//  A round-robin arbiter grants the counter to one requester and runs it from 0 to that requester's terminal count.
//  At the end it pulses done to the owner.
//  Sits between requesting control blocks and the shared counter resource.
// PARAMETERS
//  NREQ  4  number of requesters, 2..8
//  CW    4  counter / terminal-count width in bits
//  OW    $clog2(NREQ)  owner index width (localparam, derived)
// PORTS
//  clk    in   1        clock, all logic on posedge
//  rst    in   1        reset, synchronous, active-high
//  req    in   NREQ     request per requester, level; held until done or abort
//  len    in   NREQ*CW  terminal count per requester; slice i = len[i*CW +: CW]
//  gnt    out  NREQ     one-hot grant, registered
//  done   out  NREQ     one-cycle completion pulse to owner, registered
//  busy   out  1        1 while in RUN
//  cnt    out  CW       current counter value
//  owner  out  OW       index of current or last owner
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; gnt=0, done=0, busy=0, cnt=0, owner=0, ptr=0.
//   - rst has priority over all other events; mid-RUN reset produces no done pulse.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - If req!=0 at edge k: pick the first set req scanning ptr, ptr+1, ... (mod NREQ).
//   - At edge k: gnt=onehot(winner), owner=winner, tc=len[winner], cnt=0, busy=1, state->RUN.
//   - Grant latency: gnt is visible 1 cycle after req is sampled.
//   - If req==0: stay in IDLE; outputs hold, except done=0.
//  RUN:
//   - Priority order: abort, then terminal, then count.
//   - Abort: if req[owner]==0 at an edge, then gnt=0, busy=0, cnt=0, ptr=owner+1, state->IDLE, no done.
//   - Terminal: else if cnt==tc, then gnt=0, busy=0, done[owner]=1, state->DONE.
//   - Count: else cnt<=cnt+1.
//   - Ripple-free increment: bit i toggles when all lower bits are 1.
//   - cnt never wraps: tc <= 2^CW-1.
//   - RUN lasts exactly tc+1 cycles; tc=0 gives 1 RUN cycle.
//   - tc is latched at grant; len changes during RUN are ignored.
//   - req of non-owners is ignored during RUN.
//  DONE (1 cycle):
//   - done=0 next edge, cnt=0, ptr=owner+1 mod NREQ, state->IDLE.
//   - No arbitration happens in DONE.
//   - A requester still holding req is re-arbitrated in IDLE at round-robin priority.
//  owner holds its value after completion until the next grant.
//  Invariants: gnt and done are each one-hot or zero; never gnt!=0 and done!=0 in the same cycle.
//  Minimum spacing between grants: tc+3 cycles (IDLE -> RUN tc+1 -> DONE -> IDLE).
// TESTING
//  1. Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, cnt=0, owner=0 throughout.
//  2. Single: req=0001, len0=3 -> gnt=0001 next cycle; cnt=0,1,2,3;
//     then gnt=0 and done=0001 for exactly 1 cycle; busy high 4 cycles.
//  3. Zero length: req=0100, len2=0 -> gnt=0100 for 1 cycle (cnt=0), then done=0100 for 1 cycle.
//  4. Fairness: req=1111 held, every len=1 -> grant order 0,1,2,3,0;
//     each grant 2 cycles; consecutive grants 4 cycles apart.
//  5. Abort: req1 with len1=9, drop req1 when cnt=2 -> gnt=0 next edge, no done pulse;
//     with req=0100 pending, the next grant goes to requester 2.
//  6. Max count and reset mid-run: len0=15 -> cnt reaches 15 with no wrap, then done.
//     Rerun and assert rst at cnt=5 -> all outputs 0 next edge, no done;
//     after rst release with req=1010 -> requester 1 granted first.

Source files
------------

// File: rtl/tff_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tff_counter_scheduler
//   Time-shares one CW-bit synchronous up counter among NREQ requesters.
//   A round-robin arbiter grants the counter to one requester, which then
//   owns it for len+1 cycles (count 0..tc). Completion is signalled by a
//   one-cycle done pulse to the owner; dropping req while owning aborts the
//   interval without a done pulse.
//
// Ports
//   clk    in   1        clock, all logic on posedge
//   rst    in   1        synchronous active-high reset
//   req    in   NREQ     level request per requester
//   len    in   NREQ*CW  terminal count per requester, slice i = len[i*CW +: CW]
//   gnt    out  NREQ     one-hot grant, registered
//   done   out  NREQ     one-cycle completion pulse to owner, registered
//   busy   out  1        high while the counter is running
//   cnt    out  CW       current counter value
//   owner  out  OW       index of current or last owner
// -----------------------------------------------------------------------------
module tff_counter_scheduler #(
    parameter int NREQ = 4,
    parameter int CW   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*CW-1:0]        len,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic [CW-1:0]             cnt,
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int OW = $clog2(NREQ);
    localparam logic [OW-1:0]   LAST_IDX = OW'(NREQ - 1);
    localparam logic [OW-1:0]   ONE_IDX  = OW'(1);
    localparam logic [NREQ-1:0] ONE_REQ  = NREQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [NREQ-1:0]   gnt_r, gnt_s;
    logic [NREQ-1:0]   done_r, done_s;
    logic              busy_r, busy_s;
    logic [CW-1:0]     cnt_r, cnt_s;
    logic [OW-1:0]     owner_r, owner_s;
    logic [OW-1:0]     ptr_r, ptr_s;
    logic [CW-1:0]     tc_r, tc_s;
    logic [OW-1:0]     winner_s;

    // Index increment modulo NREQ (NREQ need not be a power of two).
    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
        if (idx == LAST_IDX) begin
            return '0;
        end else begin
            return idx + ONE_IDX;
        end
    endfunction

    // First set request scanning from p upward, wrapping modulo NREQ.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   p);
        logic [OW-1:0] idx;
        logic [OW-1:0] pick;
        logic          found;
        idx   = p;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
            idx = wrap_inc(idx);
        end
        return pick;
    endfunction

    // T flip-flop increment: bit i toggles when every lower bit is 1.
    function automatic logic [CW-1:0] tff_inc(input logic [CW-1:0] q);
        logic [CW-1:0] t;
        logic          all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < CW; i++) begin
            t[i]     = all_ones;
            all_ones = all_ones & q[i];
        end
        return q ^ t;
    endfunction

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign busy  = busy_r;
    assign cnt   = cnt_r;
    assign owner = owner_r;

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s  = state_r;
        gnt_s    = gnt_r;
        done_s   = '0;
        busy_s   = busy_r;
        cnt_s    = cnt_r;
        owner_s  = owner_r;
        ptr_s    = ptr_r;
        tc_s     = tc_r;
        winner_s = rr_pick(req, ptr_r);

        case (state_r)
            ST_IDLE: begin
                if (req != '0) begin
                    gnt_s   = ONE_REQ << winner_s;
                    owner_s = winner_s;
                    tc_s    = len[int'(winner_s)*CW +: CW];
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Abort outranks terminal count: a dropped request never
                // receives done, even on its final cycle.
                if (!req[owner_r]) begin
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    cnt_s   = '0;
                    ptr_s   = wrap_inc(owner_r);
                    state_s = ST_IDLE;
                end else if (cnt_r == tc_r) begin
                    gnt_s   = '0;
                    busy_s  = 1'b0;
                    done_s  = ONE_REQ << owner_r;
                    state_s = ST_DONE;
                end else begin
                    cnt_s   = tff_inc(cnt_r);
                end
            end
            ST_DONE: begin
                cnt_s   = '0;
                ptr_s   = wrap_inc(owner_r);
                state_s = ST_IDLE;
            end
            default: begin
                gnt_s   = '0;
                busy_s  = 1'b0;
                cnt_s   = '0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            gnt_r   <= '0;
            done_r  <= '0;
            busy_r  <= 1'b0;
            cnt_r   <= '0;
            owner_r <= '0;
            ptr_r   <= '0;
            tc_r    <= '0;
        end else begin
            state_r <= state_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
            owner_r <= owner_s;
            ptr_r   <= ptr_s;
            tc_r    <= tc_s;
        end
    end

endmodule

// File: tb/tb_tff_counter_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tff_counter_scheduler
//   Directed bench for tff_counter_scheduler (NREQ=4, CW=4). Each task drives
//   one scenario and compares the packed output bundle
//   {gnt, done, busy, cnt, owner} against hand-computed values, sampled 1 time
//   unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_tff_counter_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  cnt;
    logic [1:0]  owner;

    logic [14:0] obs;
    logic [14:0] exp;
    int          nvec;
    int          nerr;

    assign obs = {gnt, done, busy, cnt, owner};

    tff_counter_scheduler #(.NREQ(4), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .cnt   (cnt),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        len = {4'd3, 4'd3, 4'd3, 4'd3};
        for (int k = 0; k < 2; k++) begin
            tick();
            exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL reset cyc%0d: got %b expected %b", k, obs, exp);
            end
        end
        rst = 1'b0;
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL reset_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_single();
        len = {4'd0, 4'd0, 4'd0, 4'd3};
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = {4'b0001, 4'b0000, 1'b1, 4'(k), 2'd0};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL single_run cnt%0d: got %b expected %b", k, obs, exp);
            end
        end
        tick();
        exp = {4'b0000, 4'b0001, 1'b0, 4'd3, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL single_done: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL single_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_zero_len();
        len = {4'd0, 4'd0, 4'd0, 4'd0};
        req = 4'b0100;
        tick();
        exp = {4'b0100, 4'b0000, 1'b1, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL zero_grant: got %b expected %b", obs, exp);
        end
        tick();
        exp = {4'b0000, 4'b0100, 1'b0, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL zero_done: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL zero_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] oh;
        logic [1:0] w;
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL fair_reset: got %b expected %b", obs, exp);
        end
        len = {4'd1, 4'd1, 4'd1, 4'd1};
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w  = 2'(g % 4);
            oh = 4'b0001 << w;
            tick();
            exp = {oh, 4'b0000, 1'b1, 4'd0, w};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL fair_grant%0d: got %b expected %b", g, obs, exp);
            end
            tick();
            exp = {oh, 4'b0000, 1'b1, 4'd1, w};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL fair_count%0d: got %b expected %b", g, obs, exp);
            end
            tick();
            exp = {4'b0000, oh, 1'b0, 4'd1, w};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL fair_done%0d: got %b expected %b", g, obs, exp);
            end
            if (g == 4) req = 4'b0000;
            tick();
            exp = {4'b0000, 4'b0000, 1'b0, 4'd0, w};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL fair_idle%0d: got %b expected %b", g, obs, exp);
            end
        end
    endtask

    task automatic test_abort();
        len = {4'd0, 4'd0, 4'd9, 4'd0};
        req = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp = {4'b0010, 4'b0000, 1'b1, 4'(k), 2'd1};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL abort_run cnt%0d: got %b expected %b", k, obs, exp);
            end
        end
        req = 4'b0100;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd1};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL abort_drop: got %b expected %b", obs, exp);
        end
        tick();
        exp = {4'b0100, 4'b0000, 1'b1, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL abort_next_grant: got %b expected %b", obs, exp);
        end
        tick();
        exp = {4'b0000, 4'b0100, 1'b0, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL abort_next_done: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd2};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL abort_idle: got %b expected %b", obs, exp);
        end
    endtask

    task automatic test_max_and_reset();
        len = {4'd0, 4'd0, 4'd0, 4'd15};
        req = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            tick();
            exp = {4'b0001, 4'b0000, 1'b1, 4'(k), 2'd0};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL max_run cnt%0d: got %b expected %b", k, obs, exp);
            end
            // Terminal count is latched at grant; this change must be ignored.
            if (k == 3) len = {4'd0, 4'd0, 4'd0, 4'd2};
        end
        tick();
        exp = {4'b0000, 4'b0001, 1'b0, 4'd15, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL max_done: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL max_idle: got %b expected %b", obs, exp);
        end
        len = {4'd0, 4'd0, 4'd0, 4'd15};
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = {4'b0001, 4'b0000, 1'b1, 4'(k), 2'd0};
            nvec++;
            if (obs !== exp) begin
                nerr++;
                $display("FAIL rerun cnt%0d: got %b expected %b", k, obs, exp);
            end
        end
        rst = 1'b1;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd0};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL midrun_reset: got %b expected %b", obs, exp);
        end
        rst = 1'b0;
        req = 4'b1010;
        tick();
        exp = {4'b0010, 4'b0000, 1'b1, 4'd0, 2'd1};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL post_reset_grant: got %b expected %b", obs, exp);
        end
        tick();
        exp = {4'b0000, 4'b0010, 1'b0, 4'd0, 2'd1};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL post_reset_done: got %b expected %b", obs, exp);
        end
        req = 4'b0000;
        tick();
        exp = {4'b0000, 4'b0000, 1'b0, 4'd0, 2'd1};
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL post_reset_idle: got %b expected %b", obs, exp);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst  = 1'b1;
        req  = 4'b0000;
        len  = 16'd0;
        test_reset();
        test_single();
        test_zero_len();
        test_fairness();
        test_abort();
        test_max_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
